// File: rtl/rl_fifo_pkg.sv
// rtl/rl_fifo_pkg.sv - shared widths, read-credit limit and prefetch operation encoding
package rl_fifo_pkg;

  // Outstanding reads plus held words may never exceed the prefetch depth.
  localparam int unsigned CREDIT_LIMIT = 2;

  typedef enum logic [1:0] {
    PF_IDLE = 2'b00,
    PF_PUSH = 2'b01,
    PF_POP  = 2'b10,
    PF_BOTH = 2'b11
  } pf_op_e;

  function automatic int unsigned ptr_width(input int unsigned abits);
    return abits + 1;
  endfunction

  function automatic int unsigned level_width(input int unsigned abits);
    return abits + 2;
  endfunction

endpackage

// File: rtl/rl_fifo_prefetch.sv
// rtl/rl_fifo_prefetch.sv - 2-entry in-order register buffer feeding the pop stream
import rl_fifo_pkg::*;

module rl_fifo_prefetch #(
  parameter int unsigned DBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [DBITS-1:0] i_data,
  input  logic             i_pop,
  output logic [DBITS-1:0] o_data,
  output logic             o_valid,
  output logic [1:0]       o_count
);

  logic [DBITS-1:0] r_head;
  logic [DBITS-1:0] r_tail;
  logic [1:0]       r_count;
  pf_op_e           w_op;

  assign w_op    = pf_op_e'({i_pop, i_push});
  assign o_data  = r_head;
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

  // The head register always holds the oldest word so the output never depends on inputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case (w_op)
        PF_PUSH: begin
          if (r_count == 2'd0) r_head <= i_data;
          else                 r_tail <= i_data;
          r_count <= r_count + 2'd1;
        end
        PF_POP: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        PF_BOTH: begin
          if (r_count == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rl_fifo_ram_ctrl.sv
// rtl/rl_fifo_ram_ctrl.sv - FIFO controller around an external 1R1W RAM with FWFT prefetch output
import rl_fifo_pkg::*;

module rl_fifo_ram_ctrl #(
  parameter int unsigned ABITS      = 10,
  parameter int unsigned DBITS      = 32,
  parameter int unsigned AFULL_THR  = (1 << ABITS) - 4,
  parameter int unsigned AEMPTY_THR = 4
) (
  input  logic                   rst_ni,
  input  logic                   clk_i,
  input  logic                   flush_i,
  input  logic [DBITS-1:0]       s_data_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  output logic [DBITS-1:0]       m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [ABITS+1:0]       level_o,
  output logic                   afull_o,
  output logic                   aempty_o,
  output logic [ABITS-1:0]       ram_waddr_o,
  output logic [DBITS-1:0]       ram_din_o,
  output logic                   ram_we_o,
  output logic [(DBITS+7)/8-1:0] ram_be_o,
  output logic [ABITS-1:0]       ram_raddr_o,
  input  logic [DBITS-1:0]       ram_dout_i
);

  localparam int unsigned PW    = ptr_width(ABITS);
  localparam int unsigned LW    = level_width(ABITS);
  localparam int unsigned DEPTH = 1 << ABITS;

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          r_inflight;
  logic          r_afull;
  logic          r_aempty;

  logic [PW-1:0] w_ram_cnt;
  logic          w_ram_full;
  logic          w_ram_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_rd_issue;
  logic [1:0]    w_pf_count;
  logic [2:0]    w_credits;
  logic [LW-1:0] w_level;
  logic [LW-1:0] w_level_nxt;

  assign w_ram_cnt   = r_wptr - r_rptr;
  assign w_ram_full  = (w_ram_cnt == PW'(DEPTH));
  assign w_ram_empty = (w_ram_cnt == '0);

  assign s_ready_o = !w_ram_full && !flush_i;
  assign w_push    = s_valid_i && s_ready_o;
  assign w_pop     = m_valid_o && m_ready_i && !flush_i;

  // Reads only target entries whose write edge has already passed, so no same-address collision.
  assign w_credits  = 3'(w_pf_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_rd_issue = !w_ram_empty && !flush_i && (w_credits < 3'(CREDIT_LIMIT));

  assign w_level     = LW'(w_ram_cnt) + LW'(w_pf_count) + LW'(r_inflight);
  assign w_level_nxt = flush_i ? '0 : (w_level + LW'(w_push) - LW'(w_pop));

  // Write enable is also gated by reset so nothing reaches the RAM while rst_ni is low.
  assign ram_we_o    = w_push && rst_ni;
  assign ram_waddr_o = r_wptr[ABITS-1:0];
  assign ram_din_o   = s_data_i;
  assign ram_be_o    = '1;
  assign ram_raddr_o = r_rptr[ABITS-1:0];

  assign level_o  = w_level;
  assign afull_o  = r_afull;
  assign aempty_o = r_aempty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_inflight <= 1'b0;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
    end else begin
      if (flush_i) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_inflight <= 1'b0;
      end else begin
        if (w_push)     r_wptr <= r_wptr + PW'(1);
        if (w_rd_issue) r_rptr <= r_rptr + PW'(1);
        r_inflight <= w_rd_issue;
      end
      r_afull  <= (w_level_nxt >= LW'(AFULL_THR));
      r_aempty <= (w_level_nxt <= LW'(AEMPTY_THR));
    end
  end

  rl_fifo_prefetch #(
    .DBITS (DBITS)
  ) u_prefetch (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_flush (flush_i),
    .i_push  (r_inflight),
    .i_data  (ram_dout_i),
    .i_pop   (w_pop),
    .o_data  (m_data_o),
    .o_valid (m_valid_o),
    .o_count (w_pf_count)
  );

endmodule

// File: tb/tb_rl_fifo_ram_ctrl.sv
// tb/tb_rl_fifo_ram_ctrl.sv - scoreboard bench for rl_fifo_ram_ctrl with a behavioural RAM and queue model
module tb_rl_fifo_ram_ctrl;

  localparam int ABITS = 4;
  localparam int DBITS = 32;
  localparam int CAP   = (1 << ABITS) + 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [DBITS-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [DBITS-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [ABITS+1:0] level;
  logic             afull, aempty;
  logic [ABITS-1:0] waddr, raddr;
  logic [DBITS-1:0] din, dout;
  logic             we;
  logic [3:0]       be;

  logic [DBITS-1:0] mem [0:(1<<ABITS)-1];
  logic [DBITS-1:0] exp_q[$];
  logic             hold;
  int               n_chk = 0;
  int               n_err = 0;

  always #5 clk = ~clk;

  rl_fifo_ram_ctrl #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .rst_ni(rst_n), .clk_i(clk), .flush_i(flush),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .level_o(level), .afull_o(afull), .aempty_o(aempty),
    .ram_waddr_o(waddr), .ram_din_o(din), .ram_we_o(we), .ram_be_o(be),
    .ram_raddr_o(raddr), .ram_dout_i(dout)
  );

  always @(posedge clk) begin
    if (we) mem[waddr] <= din;
    dout <= mem[raddr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted words; level is its size.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold = 1'b0;
    end else begin
      chk("level", 64'(level), 64'(exp_q.size()));
      chk("afull", afull, exp_q.size() >= 12);
      chk("aempty", aempty, exp_q.size() <= 4);
      if (exp_q.size() < (1 << ABITS)) chk("s_ready_room", s_ready, !flush);
      if (exp_q.size() == CAP) chk("s_ready_full", s_ready, 1'b0);
      if (hold) chk("hold_valid", m_valid, 1'b1);
      if (m_valid) begin
        chk("valid_has_entry", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("head_data", m_data, exp_q[0]);
      end
      if (flush) begin
        exp_q.delete();
        hold = 1'b0;
      end else begin
        hold = m_valid && !m_ready;
        if (m_valid && m_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (s_valid && s_ready) exp_q.push_back(s_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    step();
    @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_level", 64'(level), 64'd0);
    chk("drain_valid", m_valid, 1'b0);
    step();
  endtask

  // mode 0: random valid/ready; mode 1: ready one cycle in three
  task automatic rand_run(input int n, input int mode);
    int acc = 0;
    for (int c = 0; c < 2000 && acc < n; c++) begin
      s_valid = ($urandom_range(0, 1) == 1);
      s_data  = $urandom;
      m_ready = (mode == 0) ? ($urandom_range(0, 1) == 1) : (c % 3 == 0);
      @(negedge clk);
      if (s_valid && s_ready) acc++;
      step();
    end
    chk("rand_done", 64'(acc), 64'(n));
    drain();
  endtask

  initial begin
    int acc;
    logic seen;
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b1; s_data = 32'hDEAD_BEEF; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_afull", afull, 1'b0);
    chk("rst_aempty", aempty, 1'b1);
    chk("rst_we", we, 1'b0);
    chk("rst_waddr", waddr, 4'h0);
    chk("rst_raddr", raddr, 4'h0);
    chk("rst_be", be, 4'hF);
    @(posedge clk); #1;
    rst_n = 1'b1; s_valid = 1'b0;
    step();

    // first-word latency
    s_valid = 1'b1; s_data = 32'hA5A5_A5A5;
    step();
    s_valid = 1'b0;
    @(negedge clk); chk("lat_c1", m_valid, 1'b0);
    @(negedge clk); chk("lat_c2", m_valid, 1'b0);
    @(negedge clk); chk("lat_c3", m_valid, 1'b1);
    chk("lat_data", m_data, 32'hA5A5_A5A5);
    step();
    drain();

    // fill with no pops
    acc = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_data = 32'h100 + i;
      @(negedge clk);
      if (s_ready) acc++;
      step();
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("fill_accepted", 64'(acc), 64'd18);
    chk("fill_level", 64'(level), 64'd18);
    chk("fill_s_ready", s_ready, 1'b0);
    chk("fill_afull", afull, 1'b1);
    step();
    drain();

    // streaming: one push and one pop per cycle
    seen = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1; s_data = i;
      @(negedge clk);
      if (seen) chk("stream_bubble", m_valid, 1'b1);
      if (m_valid) seen = 1'b1;
      step();
    end
    drain();

    rand_run(50, 0);
    rand_run(40, 1);

    // flush while a read is in flight
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = 32'hF000 + i;
      step();
    end
    flush = 1'b1; s_data = 32'hBAD;
    step();
    flush = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_valid", m_valid, 1'b0);
    step();
    s_valid = 1'b1; s_data = 32'h1234; m_ready = 1'b0;
    step();
    s_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m_valid) begin
        seen = 1'b1;
        chk("flush_first", m_data, 32'h1234);
      end
      step();
    end
    chk("flush_emerged", seen, 1'b1);
    drain();

    // asynchronous reset in the middle of traffic
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1; s_data = 32'hC000 + i;
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", we, 1'b0);
    chk("mid_rst_valid", m_valid, 1'b0);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_s_ready", s_ready, 1'b1);
    chk("mid_rst_waddr", waddr, 4'h0);
    @(posedge clk); #1;
    chk("mid_rst_we_held", we, 1'b0);
    rst_n = 1'b1; s_valid = 1'b0;
    step();
    rand_run(30, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
